alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the 4-op 6-bit ALU.
//  - Same op set, generalised to WIDTH-bit signed operands.
//  - Exact internal arithmetic with overflow flag; optional saturation.
//  - Two-stage valid/ready pipeline: operand register, then result register.
//  - Sits between the operand sequencer and the result writeback; takes one op per cycle.

---
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 holds operands, stage 2 holds the result and overflow flag.
// Arithmetic is done exactly at WIDTH+3 bits, then wrapped or saturated back to WIDTH bits.
module alu_pipe #(
    parameter int WIDTH    = 6,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    localparam int EW = WIDTH + 3;

    localparam logic signed [EW-1:0] E_MAX = {{4{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] E_MIN = {{4{1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [1:0]       r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;

    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic signed [EW-1:0]   w_exact;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_res;

    function automatic logic signed [EW-1:0] exact_result(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb,
        input logic [1:0]       fop
    );
        logic signed [EW-1:0] ea;
        logic signed [EW-1:0] eb;
        logic signed [EW-1:0] diff;
        logic signed [EW-1:0] res;
        ea   = {{3{fa[WIDTH-1]}}, fa};
        eb   = {{3{fb[WIDTH-1]}}, fb};
        diff = (ea <<< 1) - eb;
        case (fop)
            2'b00:   res = (ea <<< 2) + (eb >>> 1);
            2'b01:   res = ea + (eb <<< 1) + eb;
            2'b10:   res = -eb;
            2'b11:   res = diff[EW-1] ? -diff : diff;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic out_of_range(input logic signed [EW-1:0] e);
        return (e < E_MIN) || (e > E_MAX);
    endfunction

    assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);
    assign w_s1_adv  = in_valid & in_ready;
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign ovf       = r_ovf;

    // Exact result, range check and wrap/saturate selection from the stage-1 registers
    always_comb begin
        w_exact = exact_result(r_s1_a, r_s1_b, r_s1_op);
        w_ovf   = out_of_range(w_exact);
        w_res   = w_exact[WIDTH-1:0];
        if ((SATURATE != 1'b0) && w_ovf) begin
            w_res = w_exact[EW-1] ? W_MIN : W_MAX;
        end else begin
            w_res = w_exact[WIDTH-1:0];
        end
    end

    // Pipeline occupancy; a flush overrides any accept or drain in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_s1_adv | (r_s1_valid & ~w_s2_adv);
            r_s2_valid <= w_s2_adv | (r_s2_valid & ~out_ready);
        end
    end

    // Stage-1 operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_op <= 2'b00;
        end else if (w_s1_adv && !clr) begin
            r_s1_a  <= a;
            r_s1_b  <= b;
            r_s1_op <= op;
        end else begin
            r_s1_a  <= r_s1_a;
            r_s1_b  <= r_s1_b;
            r_s1_op <= r_s1_op;
        end
    end

    // Stage-2 result capture; held through stalls and flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else if (w_s2_adv && !clr) begin
            r_out <= w_res;
            r_ovf <= w_ovf;
        end else begin
            r_out <= r_out;
            r_ovf <= r_ovf;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a wrapping and a saturating instance share one input stream,
// expected exact results are queued on accept and checked by a separate monitor on each transfer.
module tb_alu_pipe;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;

    logic         in_ready0, out_valid0, ovf0;
    logic         in_ready1, out_valid1, ovf1;
    logic [W-1:0] out0, out1;

    int n_checks = 0;
    int n_fail = 0;
    int sbq[$];

    int  m_e, m_wrap, m_sat;
    int  m_ovf;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
        .out(out0), .ovf(ovf0)
    );

    alu_pipe #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .out(out1), .ovf(ovf1)
    );

    function automatic int model_e(input int x, input int y, input int o);
        int d;
        case (o)
            0:       return 4 * x + ((y >= 0) ? (y / 2) : -((1 - y) / 2));
            1:       return x + 3 * y;
            2:       return -y;
            default: begin
                d = 2 * x - y;
                return (d < 0) ? -d : d;
            end
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) sbq.delete();

    // Monitor: compare every completed transfer, then record accepts or flush on clr
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                chk("sat_valid_match", out_valid1, 1);
                chk("sb_has_entry", (sbq.size() > 0) ? 1 : 0, 1);
                if (sbq.size() > 0) begin
                    m_e    = sbq.pop_front();
                    m_ovf  = (m_e < -(1 << (W - 1)) || m_e > (1 << (W - 1)) - 1) ? 1 : 0;
                    m_wrap = ((m_e % (1 << W)) + (1 << W)) % (1 << W);
                    m_sat  = (m_ovf == 0) ? m_e : ((m_e > 0) ? (1 << (W - 1)) - 1 : -(1 << (W - 1)));
                    chk("out_wrap", int'(out0), m_wrap);
                    chk("ovf_wrap", int'(ovf0), m_ovf);
                    chk("out_sat", int'($signed(out1)), m_sat);
                    chk("ovf_sat", int'(ovf1), m_ovf);
                end
            end
            if (clr) begin
                sbq.delete();
            end else if (in_valid && in_ready0) begin
                sbq.push_back(model_e(int'($signed(a)), int'($signed(b)), int'(op)));
            end
        end
    end

    task automatic cyc(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready0 && !clr;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input int o, input int x, input int y);
        in_valid = v;
        op = o[1:0];
        a = x[W-1:0];
        b = y[W-1:0];
    endtask

    int d_op[8] = '{0, 1, 2, 3, 3, 0, 1, 2};
    int d_a[8]  = '{3, 10, 0, -20, 5, -32, 31, 0};
    int d_b[8]  = '{-4, 10, -32, 31, 3, -32, 31, 5};

    initial begin
        bit acc;
        int n_acc;
        logic [W-1:0] snap;

        #3;
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out", int'(out0), 0);
        chk("rst_ovf", int'(ovf0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Single op latency
        put(1'b1, 0, 3, -4);
        cyc(acc);
        chk("lat_accept", int'(acc), 1);
        put(1'b0, 0, 0, 0);
        chk("lat_edge1_out_valid", int'(out_valid0), 0);
        cyc(acc);
        chk("lat_edge2_out_valid", int'(out_valid0), 1);
        cyc(acc);

        // Back-to-back stream of directed corner cases
        for (int i = 0; i < 10; i++) begin
            if (i < 8) put(1'b1, d_op[i], d_a[i], d_b[i]);
            else       put(1'b0, 0, 0, 0);
            cyc(acc);
            if (i < 8) chk("stream_accept", int'(acc), 1);
            chk("stream_out_valid", int'(out_valid0), (i >= 1 && i <= 8) ? 1 : 0);
        end

        // Downstream stall with a continuous input stream
        out_ready = 1'b0;
        n_acc = 0;
        snap = '0;
        put(1'b1, $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63));
        for (int i = 0; i < 5; i++) begin
            cyc(acc);
            if (acc) begin
                n_acc++;
                put(1'b1, $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63));
            end
            if (i == 1) snap = out0;
            if (i >= 2) begin
                chk("stall_out_valid", int'(out_valid0), 1);
                chk("stall_out_hold", int'(out0), int'(snap));
                chk("stall_in_ready", int'(in_ready0), 0);
            end
        end
        chk("stall_accepts", n_acc, 2);
        put(1'b0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (3) cyc(acc);
        chk("stall_drained", sbq.size(), 0);

        // Flush of a full pipe with a competing accept
        out_ready = 1'b0;
        put(1'b1, 1, 7, -2);
        repeat (2) cyc(acc);
        out_ready = 1'b1;
        clr = 1'b1;
        put(1'b1, 2, 0, 9);
        cyc(acc);
        clr = 1'b0;
        put(1'b0, 0, 0, 0);
        #1;
        chk("clr_out_valid", int'(out_valid0), 0);
        chk("clr_in_ready", int'(in_ready0), 1);
        cyc(acc);
        chk("clr_no_accept", int'(out_valid0), 0);
        cyc(acc);
        chk("clr_still_empty", int'(out_valid0), 0);

        // Asynchronous reset mid-stream
        put(1'b1, 1, -3, 4);
        repeat (3) cyc(acc);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid0), 0);
        chk("arst_in_ready", int'(in_ready0), 1);
        chk("arst_out", int'(out0), 0);
        chk("arst_ovf", int'(ovf1), 0);
        put(1'b1, 2, 0, 7);
        #1 rst_n = 1'b1;
        cyc(acc);
        chk("arst_first_accept", int'(acc), 1);
        put(1'b0, 0, 0, 0);
        chk("arst_edge1_out_valid", int'(out_valid0), 0);
        cyc(acc);
        chk("arst_edge2_out_valid", int'(out_valid0), 1);
        cyc(acc);

        // Randomized traffic with backpressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                $urandom_range(0, 63), $urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 59) == 0);
            cyc(acc);
        end
        clr = 1'b0;
        put(1'b0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (4) cyc(acc);
        chk("final_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
